// File: rtl/apb_bus_arbiter_if.sv
// rtl/apb_bus_arbiter_if.sv - requester-side and APB-side signal bundle for apb_bus_arbiter
// master modport is the arbiter's view; slave modport is the surrounding requesters and APB fabric.
interface apb_bus_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int SEL_WIDTH  = 2,
   parameter int NUM_REQ    = 2
);
   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata;
   logic [NUM_REQ-1:0]            i_wr;
   logic [NUM_REQ*SEL_WIDTH-1:0]  i_sel;
   logic [NUM_REQ-1:0]            o_gnt;
   logic [NUM_REQ-1:0]            o_done;
   logic [DATA_WIDTH-1:0]         o_rdata;
   logic                          o_err;
   logic [ADDR_WIDTH-1:0]         o_paddr;
   logic [SEL_WIDTH-1:0]          o_psel;
   logic                          o_penable;
   logic                          o_pwrite;
   logic [DATA_WIDTH-1:0]         o_pwdata;
   logic [DATA_WIDTH-1:0]         i_prdata;
   logic                          i_pready;

   modport master (
      input  i_req, i_addr, i_wdata, i_wr, i_sel, i_prdata, i_pready,
      output o_gnt, o_done, o_rdata, o_err, o_paddr, o_psel, o_penable, o_pwrite, o_pwdata
   );

   modport slave (
      output i_req, i_addr, i_wdata, i_wr, i_sel, i_prdata, i_pready,
      input  o_gnt, o_done, o_rdata, o_err, o_paddr, o_psel, o_penable, o_pwrite, o_pwdata
   );
endinterface

// File: rtl/apb_bus_arbiter.sv
// rtl/apb_bus_arbiter.sv - round-robin arbiter sharing one APB master port between NUM_REQ requesters
// Optional ACCESS-phase wait timeout is compiled in with APB_TIMEOUT_EN.
module apb_bus_arbiter #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int SEL_WIDTH      = 2,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic            i_clk,
   input  logic            i_rst,
   apb_bus_arbiter_if.master bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                 state_q;
   logic [PTR_W-1:0]       ptr_q;
   logic [NUM_REQ-1:0]     gnt_q;
   logic [ADDR_WIDTH-1:0]  paddr_q;
   logic [DATA_WIDTH-1:0]  pwdata_q;
   logic                   pwrite_q;
   logic [SEL_WIDTH-1:0]   psel_q;
   logic                   penable_q;
   logic [DATA_WIDTH-1:0]  rdata_q;

   logic [PTR_W-1:0]       pick_d;
   logic                   pick_valid_d;
   logic                   timeout_d;
   logic                   finish_d;
   int                     scan_idx;

   // Scan from ptr+1 upward so the last-served requester has lowest priority.
   always_comb begin
      pick_d       = '0;
      pick_valid_d = 1'b0;
      scan_idx     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         scan_idx = int'(ptr_q) + i;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!pick_valid_d && bus.i_req[scan_idx]) begin
            pick_valid_d = 1'b1;
            pick_d       = PTR_W'(scan_idx);
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_q;
   assign timeout_d = (state_q == ACCESS) && !bus.i_pready &&
                      (wait_q == CNT_W'(TIMEOUT_CYCLES));
`else
   assign timeout_d = 1'b0;
`endif

   // A zero-select transfer completes in SETUP without ever touching the bus.
   assign finish_d = ((state_q == SETUP) && (psel_q == '0)) ||
                     ((state_q == ACCESS) && (bus.i_pready || timeout_d));

   assign bus.o_done    = finish_d ? gnt_q : '0;
   assign bus.o_err     = timeout_d;
   assign bus.o_gnt     = gnt_q;
   assign bus.o_rdata   = rdata_q;
   assign bus.o_paddr   = paddr_q;
   assign bus.o_psel    = psel_q;
   assign bus.o_penable = penable_q;
   assign bus.o_pwrite  = pwrite_q;
   assign bus.o_pwdata  = pwdata_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         ptr_q     <= PTR_W'(NUM_REQ - 1);
         gnt_q     <= '0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         rdata_q   <= '0;
`ifdef APB_TIMEOUT_EN
         wait_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid_d) begin
                  paddr_q  <= bus.i_addr[int'(pick_d)*ADDR_WIDTH +: ADDR_WIDTH];
                  pwdata_q <= bus.i_wdata[int'(pick_d)*DATA_WIDTH +: DATA_WIDTH];
                  pwrite_q <= bus.i_wr[pick_d];
                  psel_q   <= bus.i_sel[int'(pick_d)*SEL_WIDTH +: SEL_WIDTH];
                  gnt_q    <= NUM_REQ'(1) << pick_d;
                  ptr_q    <= pick_d;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               if (psel_q == '0) begin
                  gnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  penable_q <= 1'b1;
                  state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                  wait_q    <= '0;
`endif
               end
            end
            ACCESS: begin
               if (bus.i_pready || timeout_d) begin
                  if (timeout_d) rdata_q <= '0;
                  else if (!pwrite_q) rdata_q <= bus.i_prdata;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  gnt_q     <= '0;
                  state_q   <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else begin
                  wait_q <= wait_q + 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
- Shares one APB master port between NUM_REQ requesters, e.g. controller_core load/store traffic and a DMA/dump engine.
- Arbitration is round-robin, one transfer at a time.
- Each transfer runs the APB SETUP then ACCESS phases, waits for the slave's ready, then returns read data and a one-cycle done pulse to the granted requester.
- Sits between the requesters and the APB slave select/enable fabric.

Parameters:
- DATA_WIDTH, 16, width of write/read data.
- ADDR_WIDTH, 16, width of the APB address.
- SEL_WIDTH, 2, number of one-hot slave select lines.
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 15, maximum ACCESS-phase wait cycles when the timeout feature is compiled in.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_req  input  NUM_REQ  per-requester transfer request; held until the matching o_done.
- i_addr  input  NUM_REQ*ADDR_WIDTH  flattened request addresses; requester k uses slice k.
- i_wdata  input  NUM_REQ*DATA_WIDTH  flattened write data.
- i_wr  input  NUM_REQ  1 = write, 0 = read.
- i_sel  input  NUM_REQ*SEL_WIDTH  flattened one-hot slave select per request.
- o_gnt  output  NUM_REQ  one-hot grant; held from latch cycle through the done cycle.
- o_done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- o_rdata  output  DATA_WIDTH  read data of the last completed read.
- o_err  output  1  one-cycle pulse with o_done when a transfer is aborted.
- o_paddr  output  ADDR_WIDTH  APB address.
- o_psel  output  SEL_WIDTH  APB slave selects.
- o_penable  output  1  APB enable.
- o_pwrite  output  1  APB write.
- o_pwdata  output  DATA_WIDTH  APB write data.
- i_prdata  input  DATA_WIDTH  APB read data.
- i_pready  input  1  APB slave ready.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - All outputs go to 0.
  - State goes to IDLE.
  - Round-robin pointer goes to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer aborts the transfer immediately. No o_done is issued and the bus drops to idle on that edge.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - If any i_req bit is set, pick the first set bit scanning from ptr+1 upward, modulo NUM_REQ.
  - Latch that requester's addr, wdata, wr and sel into o_paddr, o_pwdata, o_pwrite and o_psel.
  - Set o_gnt one-hot, set ptr to the granted index, go to SETUP.
  - o_penable stays 0.
- SETUP (1 cycle):
  - Next state is ACCESS with o_penable=1.
  - If the latched sel is all zeros, no bus phase runs. o_psel stays 0, o_done[g] pulses in this cycle, o_rdata is unchanged, and the state returns to IDLE.
- ACCESS:
  - Hold all APB outputs stable while i_pready=0.
  - On i_pready=1:
    - o_done[g]=1 for one cycle.
    - If the transfer is a read, o_rdata <= i_prdata.
    - Next cycle o_psel, o_penable and o_gnt go to 0, and the state returns to IDLE.
- Minimum 3 cycles per transfer, request to done: IDLE, SETUP, ACCESS with i_pready=1.
- At least one IDLE cycle between transfers; there are no back-to-back SETUP phases.
- Requests arriving during a transfer wait. Only i_req is sampled in IDLE. Changes to a granted requester's inputs after latching are ignored.
- Deasserting i_req while granted does not cancel the transfer.
- Simultaneous requests resolve by round-robin only. After serving k, requester k has lowest priority next time.
- Multi-hot i_sel slices are passed through unchanged; the slave fabric handles them.
- o_err stays 0 except under APB_TIMEOUT_EN.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering ACCESS and increments each ACCESS cycle with i_pready=0.
  - When the counter reaches TIMEOUT_CYCLES with i_pready still 0, the transfer aborts:
    - o_done[g]=1 and o_err=1 for one cycle.
    - o_rdata <= 0.
    - Return to IDLE.
  - If i_pready=1 arrives in the same cycle the counter reaches TIMEOUT_CYCLES, this is normal completion, not an error.
- Undefined:
  - ACCESS waits indefinitely.
  - o_err is tied to 0.
  - No counter is instantiated.

Test Plan:
- Single read, NUM_REQ=2. req0 reads addr 0x0003 with sel 2'b01; slave i_pready=1 on the first ACCESS cycle with i_prdata=0xBEEF. Expect o_psel=01 for 2 cycles, o_penable only in the second, o_done[0] on cycle 3, o_rdata=0xBEEF.
- Write with wait states. req1 writes 0x1234 to 0x0005 with sel 2'b10; i_pready=0 for 3 ACCESS cycles. Expect o_pwdata and o_paddr stable for 4 ACCESS cycles, o_done[1] once, o_rdata unchanged.
- Round-robin. i_req=2'b11 held continuously for 4 transfers after reset. Expect grant order 0,1,0,1, with one IDLE cycle between transfers.
- Zero select. req0 with sel 2'b00. Expect o_done[0] in the SETUP cycle, o_psel and o_penable never 1.
- Reset mid-ACCESS. Assert i_rst while i_pready=0. Expect all outputs 0 on the next edge, no o_done, and the next request is served from requester 0 first.
- Timeout, APB_TIMEOUT_EN defined. i_pready held 0. Expect o_done and o_err together after 15 wait cycles with o_rdata=0. Without the macro, expect no done after 100 cycles and o_err=0.
